// File: rtl/ext_int_ctl.sv
// External interrupt controller: per-source priority, threshold, enable and
// edge/level capture, with a claim/complete handshake toward a single core.
module ext_int_ctl #(
    parameter int                    NumSources = 8,
    parameter int                    PrioWidth  = 3,
    parameter logic [NumSources-1:0] EdgeMask   = '0,
    localparam int                   IdWidth    = $clog2(NumSources + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NumSources-1:0] src,
    input  logic                  cfg_we,
    input  logic [7:0]            cfg_addr,
    input  logic [31:0]           cfg_wdata,
    output logic [31:0]           cfg_rdata,
    input  logic                  claim,
    output logic [IdWidth-1:0]    claim_id,
    input  logic                  complete,
    input  logic [IdWidth-1:0]    complete_id,
    output logic                  exti
);

    logic [PrioWidth-1:0]  threshold_q, threshold_d;
    logic [NumSources-1:0] enable_q, enable_d;
    logic [PrioWidth-1:0]  prio_q [NumSources];
    logic [PrioWidth-1:0]  prio_d [NumSources];
    logic [NumSources-1:0] pending_q, pending_d;
    logic [NumSources-1:0] in_service_q, in_service_d;
    logic [NumSources-1:0] src_q, src_d;
    logic                  exti_q, exti_d;

    logic [NumSources-1:0] edge_ev;
    logic [NumSources-1:0] eligible;
    logic [NumSources-1:0] win_oh;
    logic [IdWidth-1:0]    win_id;
    logic [PrioWidth-1:0]  win_prio;
    logic                  have_win;
    logic                  take;
    logic                  unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    // Arbitration: strict '>' keeps the lowest index on equal priority.
    always_comb begin
        eligible = '0;
        win_oh   = '0;
        win_id   = '0;
        win_prio = '0;
        have_win = 1'b0;
        for (int i = 0; i < NumSources; i++) begin
            eligible[i] = pending_q[i] & enable_q[i] & ~in_service_q[i]
                          & (prio_q[i] > threshold_q);
        end
        for (int i = 0; i < NumSources; i++) begin
            if (eligible[i] && (!have_win || (prio_q[i] > win_prio))) begin
                have_win  = 1'b1;
                win_prio  = prio_q[i];
                win_id    = IdWidth'(i + 1);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    assign take     = claim & have_win;
    assign claim_id = take ? win_id : '0;
    assign exti     = exti_q;

    // Claim is applied after complete so that completing the source being
    // claimed in the same cycle leaves it in service.
    always_comb begin
        edge_ev      = src & ~src_q;
        src_d        = src;
        exti_d       = |eligible;
        in_service_d = in_service_q;
        for (int i = 0; i < NumSources; i++) begin
            if (complete && (complete_id == IdWidth'(i + 1))) begin
                in_service_d[i] = 1'b0;
            end
        end
        if (take) begin
            in_service_d = in_service_d | win_oh;
        end
        pending_d = pending_q;
        for (int i = 0; i < NumSources; i++) begin
            if (EdgeMask[i]) begin
                pending_d[i] = (take && win_oh[i]) ? edge_ev[i]
                                                   : (pending_q[i] | edge_ev[i]);
            end else begin
                pending_d[i] = src[i] & ~in_service_d[i];
            end
        end
    end

    always_comb begin
        threshold_d = threshold_q;
        enable_d    = enable_q;
        prio_d      = prio_q;
        if (cfg_we) begin
            if (cfg_addr == 8'h00) threshold_d = cfg_wdata[PrioWidth-1:0];
            if (cfg_addr == 8'h01) enable_d = cfg_wdata[NumSources-1:0];
            for (int i = 0; i < NumSources; i++) begin
                if (cfg_addr == 8'(i + 2)) prio_d[i] = cfg_wdata[PrioWidth-1:0];
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        if (cfg_addr == 8'h00) cfg_rdata[PrioWidth-1:0] = threshold_q;
        if (cfg_addr == 8'h01) cfg_rdata[NumSources-1:0] = enable_q;
        if (cfg_addr == 8'h40) cfg_rdata[NumSources-1:0] = pending_q;
        if (cfg_addr == 8'h41) cfg_rdata[NumSources-1:0] = in_service_q;
        for (int i = 0; i < NumSources; i++) begin
            if (cfg_addr == 8'(i + 2)) cfg_rdata[PrioWidth-1:0] = prio_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            threshold_q  <= '0;
            enable_q     <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            src_q        <= '0;
            exti_q       <= 1'b0;
            for (int i = 0; i < NumSources; i++) begin
                prio_q[i] <= '0;
            end
        end else begin
            threshold_q  <= threshold_d;
            enable_q     <= enable_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            src_q        <= src_d;
            exti_q       <= exti_d;
            for (int i = 0; i < NumSources; i++) begin
                prio_q[i] <= prio_d[i];
            end
        end
    end

endmodule

// File: doc/ext_int_ctl.md
EXT_INT_CTL -- requirements
Module: ext_int_ctl

Interface
REQ-001 SHALL have parameter NumSources, default 8, number of external interrupt sources, legal range 1..31.
REQ-002 SHALL have parameter PrioWidth, default 3, width of each per-source priority and of the threshold.
REQ-003 SHALL have parameter EdgeMask, default all zeros, NumSources bits: bit i=1 makes source i edge-triggered, 0 makes it level-triggered.
REQ-004 SHALL define IdWidth = clog2(NumSources+1); source i (bit i of src) has ID i+1; ID 0 means "none".
REQ-005 SHALL have ports, one clock and reset synchronous active-low:
 clk  in  1  clock
 rst_n  in  1  synchronous active-low reset
 src  in  NumSources  raw interrupt requests, already synchronous to clk
 cfg_we  in  1  config write strobe
 cfg_addr  in  8  config word address
 cfg_wdata  in  32  config write data
 cfg_rdata  out  32  config read data, combinational from cfg_addr
 claim  in  1  one-cycle claim request
 claim_id  out  IdWidth  combinational ID of the source claimed this cycle
 complete  in  1  one-cycle completion strobe
 complete_id  in  IdWidth  ID being completed
 exti  out  1  registered interrupt request to core

Function
REQ-006 SHALL map config: addr 0 = threshold[PrioWidth-1:0]; addr 1 = enable[NumSources-1:0]; addr 2+i = priority of source i; addr 0x40 = pending (read-only); addr 0x41 = in_service (read-only).
REQ-007 SHALL zero-extend all read fields; unmapped addresses SHALL read 0 and ignore writes; writes SHALL take effect at the next clock edge.
REQ-008 SHALL register src into src_q each cycle; edge event for source i = src[i] & ~src_q[i].
REQ-009 Edge source: pending SHALL set on an edge event regardless of enable or in_service; a second edge while pending is already set SHALL be absorbed.
REQ-010 Level source: pending SHALL equal src[i] & ~in_service[i], updated every edge.
REQ-011 Source i is eligible when pending[i] & enable[i] & ~in_service[i] & (priority[i] > threshold); priority 0 SHALL never be eligible.
REQ-012 Winner SHALL be the eligible source with highest priority; ties SHALL go to the lowest index.
REQ-013 exti SHALL be registered: high in cycle N+1 when any source is eligible in cycle N.
REQ-014 claim_id SHALL equal winner ID while claim=1 and a winner exists, else 0.
REQ-015 Claim with winner: pending of winner SHALL clear and in_service SHALL set at the next edge; claim with no winner SHALL change no state.
REQ-016 Edge event on the winner in its claim cycle: pending SHALL remain set (edge not lost), in_service still sets.
REQ-017 complete with complete_id in 1..NumSources and matching in_service bit SHALL clear that bit at the next edge; otherwise it SHALL be ignored.
REQ-018 Claim and complete in the same cycle SHALL both take effect; completing the source being claimed SHALL leave in_service set (claim wins).
REQ-019 Multiple sources SHALL be allowed in service simultaneously (nesting by the core's software).

Reset
REQ-020 On rst_n=0 at a clock edge: threshold, enable, all priorities, pending, in_service, src_q and exti SHALL be 0; cfg_rdata then reads 0 for every address.
REQ-021 Reset SHALL override any simultaneous claim, complete or cfg_we.

Verification
REQ-022 Edge priority: N=8, prio[2]=5, prio[5]=5, prio[6]=7, enable=0xFF, threshold=0; pulse src[2],src[5],src[6] same cycle -> exti high 2 cycles later; claims return IDs 7, 3, 6 in that order.
REQ-023 Threshold: prio[0]=2, threshold=2, src[0] held high -> exti stays 0; write threshold=1 -> exti high next-plus-one cycle.
REQ-024 Level in-service: src[1] high, prio=3, claim -> claim_id=2, exti drops; src held -> no re-assertion until complete_id=2, then exti high again 2 cycles later.
REQ-025 Edge during claim: claim source 4 (ID 5) in same cycle as new src[4] edge -> in_service bit 4 set, pending bit 4 still 1 (addr 0x40 reads 0x10).
REQ-026 Bogus complete/claim: complete_id=0 or unclaimed ID -> in_service unchanged; claim with nothing eligible -> claim_id=0, no state change.
REQ-027 Mid-operation reset: sources in service and pending, assert rst_n=0 one cycle -> all config reads 0, exti 0, claim_id 0.
